// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED mode controller.
// Optional BLINK mode is enabled by defining LED_CTRL_BLINK_EN.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STEP   = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HELD = 2'd1,
    P_LONG = 2'd2
  } press_e;

  localparam logic [3:0] LED_ALL_ON  = 4'b1111;
  localparam logic [3:0] LED_ALL_OFF = 4'b0000;
  localparam logic [3:0] LED_FIRST   = 4'b0001;

  // Mode advanced by a long press.
  function automatic mode_e next_mode(input mode_e m);
`ifdef LED_CTRL_BLINK_EN
    case (m)
      MODE_STEP:   return MODE_ROTATE;
      MODE_ROTATE: return MODE_BLINK;
      default:     return MODE_STEP;
    endcase
`else
    return (m == MODE_STEP) ? MODE_ROTATE : MODE_STEP;
`endif
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: counts 0..TICK_CNT-1, one-cycle tick on the last count.
// A synchronous clear restarts the count from zero.
module led_tick_gen #(
  parameter int unsigned CW       = 24,
  parameter int unsigned TICK_CNT = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [CW-1:0] TickMax = CW'(TICK_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at the terminal count.
  always_comb begin
    tick_o = (cnt_q == TickMax);
    cnt_d  = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Button-driven LED mode controller: short/long press classification and
// STEP / ROTATE / (optional) BLINK LED sequencing.
// Define LED_CTRL_BLINK_EN to build the BLINK mode.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CW       = 24,
  parameter int unsigned LONG_CNT = 10_000_000,
  parameter int unsigned TICK_CNT = 5_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       but_deb,
  output logic [3:0] ledo,
  output logic [1:0] mode,
  output logic       long_evt
);

  localparam logic [CW-1:0] LongMax = CW'(LONG_CNT - 1);

  logic          but_deb_1d_q, but_deb_1d_d;
  logic          armed_q, armed_d;
  press_e        pstate_q, pstate_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
`ifdef LED_CTRL_BLINK_EN
  logic          phase_q, phase_d;
`endif

  logic press, release_evt, short_evt, tick;

  // A level held low through reset must be seen released before a press counts.
  always_comb begin
    but_deb_1d_d = but_deb;
    armed_d      = armed_q | but_deb;
    press        = armed_q & but_deb_1d_q & ~but_deb;
    release_evt  = ~but_deb_1d_q & but_deb;
  end

  // Press classifier: short on early release, long once the hold reaches LONG_CNT-1.
  always_comb begin
    pstate_d   = pstate_q;
    hold_cnt_d = hold_cnt_q;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    case (pstate_q)
      P_IDLE: begin
        if (press) begin
          pstate_d   = P_HELD;
          hold_cnt_d = '0;
        end
      end
      P_HELD: begin
        if (release_evt) begin
          short_evt = (hold_cnt_q < LongMax);
          pstate_d  = P_IDLE;
        end else if (hold_cnt_q == LongMax) begin
          long_evt = 1'b1;
          pstate_d = P_LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      P_LONG: begin
        if (release_evt) begin
          pstate_d = P_IDLE;
        end
      end
      default: pstate_d = P_IDLE;
    endcase
  end

  led_tick_gen #(
    .CW       (CW),
    .TICK_CNT (TICK_CNT)
  ) u_tick_gen (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (long_evt),
    .tick_o (tick)
  );

  // Mode scheduler: a long press changes mode and swallows any coincident tick.
  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
`ifdef LED_CTRL_BLINK_EN
    phase_d = phase_q;
`endif
    if (long_evt) begin
      mode_d  = next_mode(mode_q);
`ifdef LED_CTRL_BLINK_EN
      phase_d = 1'b0;
`endif
    end else begin
      case (mode_q)
        MODE_STEP: begin
          if (short_evt) pos_d = pos_q + 2'd1;
        end
        MODE_ROTATE: begin
          // The step uses the direction after any same-cycle toggle.
          dir_d = dir_q ^ short_evt;
          if (tick) pos_d = dir_d ? (pos_q - 2'd1) : (pos_q + 2'd1);
        end
`ifdef LED_CTRL_BLINK_EN
        MODE_BLINK: begin
          if (tick) phase_d = ~phase_q;
        end
`endif
        default: ;
      endcase
    end
  end

  // LED decode from registered state only.
  always_comb begin
    ledo = LED_FIRST << pos_q;
`ifdef LED_CTRL_BLINK_EN
    if (mode_q == MODE_BLINK) begin
      ledo = phase_q ? LED_ALL_ON : LED_ALL_OFF;
    end
`endif
    mode = mode_q;
  end

  // Controller state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      but_deb_1d_q <= 1'b1;
      armed_q      <= 1'b0;
      pstate_q     <= P_IDLE;
      hold_cnt_q   <= '0;
      mode_q       <= MODE_STEP;
      pos_q        <= 2'd0;
      dir_q        <= 1'b0;
`ifdef LED_CTRL_BLINK_EN
      phase_q      <= 1'b0;
`endif
    end else begin
      but_deb_1d_q <= but_deb_1d_d;
      armed_q      <= armed_d;
      pstate_q     <= pstate_d;
      hold_cnt_q   <= hold_cnt_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
`ifdef LED_CTRL_BLINK_EN
      phase_q      <= phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with LONG_CNT=8, TICK_CNT=4.
// Covers both builds: BLINK checks when LED_CTRL_BLINK_EN is defined, STEP/ROTATE-only otherwise.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       but_deb;
  logic [3:0] ledo;
  logic [1:0] mode;
  logic       long_evt;

  int n_vec     = 0;
  int n_miss    = 0;
  int cyc_n     = 0;
  int long_seen = 0;
  int long_cyc  = -1;
  int press_cyc = 0;
  int base_long = 0;
`ifndef LED_CTRL_BLINK_EN
  int saw_mode2 = 0;
`endif

  led_mode_ctrl #(
    .CW       (8),
    .LONG_CNT (8),
    .TICK_CNT (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .but_deb  (but_deb),
    .ledo     (ledo),
    .mode     (mode),
    .long_evt (long_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Record every long pulse and when it happened.
  always @(negedge clk) begin
    if (long_evt === 1'b1) begin
      long_seen = long_seen + 1;
      long_cyc  = cyc_n;
    end
`ifndef LED_CTRL_BLINK_EN
    if (mode == 2'd2) saw_mode2 = 1;
`endif
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic short_press(input int low_cycles);
    but_deb = 1'b0;
    cyc(low_cycles);
    but_deb = 1'b1;
    cyc(1);
  endtask

  logic [3:0] exp_step [4];

  initial begin
    exp_step[0] = 4'b0010;
    exp_step[1] = 4'b0100;
    exp_step[2] = 4'b1000;
    exp_step[3] = 4'b0001;

    rstn    = 1'b0;
    but_deb = 1'b1;
    cyc(3);
    chk_eq("rst_ledo", ledo, 4'b0001);
    chk_eq("rst_mode", mode, 2'd0);
    chk_eq("rst_long", long_evt, 1'b0);
    rstn = 1'b1;
    cyc(2);

    // STEP: four short presses walk the LED and wrap.
    for (int i = 0; i < 4; i++) begin
      short_press(3);
      chk_eq("step_ledo", ledo, exp_step[i]);
      cyc(2);
    end
    chk_eq("step_no_long", long_seen, 0);
    chk_eq("step_mode", mode, 2'd0);

    // Long press into ROTATE; long pulse 8 cycles after press detect.
    but_deb   = 1'b0;
    press_cyc = cyc_n;
    cyc(12);
    chk_eq("long_mode", mode, 2'd1);
    chk_eq("long_hold_ledo", ledo, 4'b0001);
    but_deb = 1'b1;
    cyc(1);
    chk_eq("rot_t1", ledo, 4'b0010);
    chk_eq("long_count", long_seen, 1);
    chk_eq("long_latency", long_cyc - press_cyc, 8);
    cyc(4);
    chk_eq("rot_t2", ledo, 4'b0100);

    // Short press at pos 2 reverses direction.
    but_deb = 1'b0;
    cyc(2);
    but_deb = 1'b1;
    cyc(2);
    chk_eq("rev_a", ledo, 4'b0010);
    cyc(4);
    chk_eq("rev_b", ledo, 4'b0001);
    cyc(4);
    chk_eq("rev_c", ledo, 4'b1000);

    // Short release coincides with a tick: step goes in the new (up) direction.
    but_deb = 1'b0;
    cyc(3);
    but_deb = 1'b1;
    cyc(1);
    chk_eq("coinc_step", ledo, 4'b0001);
    cyc(3);

    // Long press timed so the long event lands on a tick.
    but_deb = 1'b0;
    cyc(1);
    chk_eq("rot_up", ledo, 4'b0010);
    cyc(8);
`ifdef LED_CTRL_BLINK_EN
    chk_eq("blink_mode", mode, 2'd2);
    chk_eq("blink_off0", ledo, 4'b0000);
    cyc(3);
    but_deb = 1'b1;
    cyc(1);
    chk_eq("blink_on1", ledo, 4'b1111);
    short_press(3);
    chk_eq("blink_short_ign", ledo, 4'b0000);
    chk_eq("blink_mode_kept", mode, 2'd2);
    cyc(4);
    chk_eq("blink_on2", ledo, 4'b1111);
    but_deb = 1'b0;
    cyc(9);
    chk_eq("blink_exit_mode", mode, 2'd0);
    chk_eq("blink_exit_ledo", ledo, 4'b0100);
    cyc(3);
    but_deb = 1'b1;
    cyc(2);
    chk_eq("blink_long_count", long_seen, 3);
`else
    chk_eq("rot_exit_mode", mode, 2'd0);
    chk_eq("rot_exit_ledo", ledo, 4'b0100);
    cyc(3);
    but_deb = 1'b1;
    cyc(5);
    chk_eq("step_tick_ign", ledo, 4'b0100);
    chk_eq("step_mode_kept", mode, 2'd0);
    short_press(3);
    chk_eq("step_again", ledo, 4'b1000);
    chk_eq("no_mode2", saw_mode2, 0);
    chk_eq("nb_long_count", long_seen, 2);
    cyc(2);
`endif

    // Reset asserted mid-hold (5 of 8 cycles), button held across release.
    but_deb = 1'b0;
    cyc(5);
    #2;
    rstn = 1'b0;
    #1;
    chk_eq("mh_rst_ledo", ledo, 4'b0001);
    chk_eq("mh_rst_mode", mode, 2'd0);
    chk_eq("mh_rst_long", long_evt, 1'b0);
    cyc(2);
    rstn      = 1'b1;
    base_long = long_seen;
    cyc(12);
    chk_eq("held_thru_rst_long", long_seen, base_long);
    chk_eq("held_thru_rst_mode", mode, 2'd0);
    but_deb = 1'b1;
    cyc(3);
    chk_eq("held_thru_rst_rel", ledo, 4'b0001);
    short_press(3);
    chk_eq("repress_step", ledo, 4'b0010);
    cyc(2);

    // Reset asserted while rotating.
    but_deb = 1'b0;
    cyc(12);
    chk_eq("rot2_mode", mode, 2'd1);
    but_deb = 1'b1;
    cyc(2);
    chk_eq("rot2_ledo", ledo, 4'b0100);
    #2;
    rstn = 1'b0;
    #1;
    chk_eq("mr_rst_ledo", ledo, 4'b0001);
    chk_eq("mr_rst_mode", mode, 2'd0);
    chk_eq("mr_rst_long", long_evt, 1'b0);
    cyc(2);
    rstn = 1'b1;
    cyc(6);
    chk_eq("post_rst_ledo", ledo, 4'b0001);
    chk_eq("post_rst_mode", mode, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
